// File: rtl/seq_core_pkg.sv
// Shared encodings for the sequential core: opcodes, instruction field positions, NOP word,
// plus the operand-read predicate used for load-use detection.
package seq_core_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_LOADC = 4'h6;
    localparam logic [3:0] OP_LOAD  = 4'h7;
    localparam logic [3:0] OP_STORE = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_JMPR  = 4'hA;
    localparam logic [3:0] OP_JMPRZ = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int OP_LO = 12;
    localparam int D_LO  = 9;
    localparam int S0_LO = 6;
    localparam int S1_LO = 3;

    localparam logic [15:0] IR_NOP = 16'h0000;

    // True when instruction word w reads register r as a source operand.
    function automatic logic ir_reads(input logic [15:0] w, input logic [2:0] r);
        logic [3:0] o;
        o = w[OP_LO+:4];
        case (o)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STORE:
                ir_reads = (w[S0_LO+:3] == r) || (w[S1_LO+:3] == r);
            OP_LOAD, OP_JMP: ir_reads = (w[S0_LO+:3] == r);
            OP_JMPRZ:        ir_reads = (w[D_LO+:3] == r);
            default:         ir_reads = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_core_regfile.sv
// 8-entry register file, two combinational read ports, one synchronous write port, no reset.
module seq_core_regfile #(
    parameter int D_SIZE = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [D_SIZE-1:0] wr_data,
    input  logic [2:0]        rd_addr0,
    output logic [D_SIZE-1:0] rd_data0,
    input  logic [2:0]        rd_addr1,
    output logic [D_SIZE-1:0] rd_data1
);

    logic [D_SIZE-1:0] mem [8];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data0 = mem[rd_addr0];
    assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/seq_core_read.sv
// Decode/operand-read stage: register-file read with r3/wb forwarding, jump and halt
// resolution toward fetch, and load-use bubble generation.
module seq_core_read
    import seq_core_pkg::*;
#(
    parameter int A_SIZE = 10,
    parameter int D_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       ir,
    output logic              r2_pc_halt,
    output logic              r2_pc_load,
    output logic              r2_pc_loadr,
    output logic [A_SIZE-1:0] r2_pc_target,
    output logic              r2_pc_flush,
    output logic              bubble,
    output logic              r2_valid,
    output logic [3:0]        r2_opcode,
    output logic [2:0]        r2_dst,
    output logic [D_SIZE-1:0] r2_op0,
    output logic [D_SIZE-1:0] r2_op1,
    input  logic              r3_we,
    input  logic [2:0]        r3_dst,
    input  logic [D_SIZE-1:0] r3_data,
    input  logic              wb_we,
    input  logic [2:0]        wb_dst,
    input  logic [D_SIZE-1:0] wb_data
);

    logic [3:0]        op;
    logic [2:0]        fd, fs0, fs1, ra0;
    logic [D_SIZE-1:0] rf0, rf1, v0, v1;
    logic [A_SIZE-1:0] rel_tgt;

    assign op  = ir[OP_LO+:4];
    assign fd  = ir[D_LO+:3];
    assign fs0 = ir[S0_LO+:3];
    assign fs1 = ir[S1_LO+:3];
    // JMPRZ tests R[d], so read port 0 is steered to d for that opcode.
    assign ra0 = (op == OP_JMPRZ) ? fd : fs0;

    // Fetch pc is already J+2 when it applies the offset.
    assign rel_tgt = {{(A_SIZE-6){ir[5]}}, ir[5:0]} - A_SIZE'(2);

    seq_core_regfile #(.D_SIZE(D_SIZE)) u_rf (
        .clk      (clk),
        .wr_en    (wb_we),
        .wr_addr  (wb_dst),
        .wr_data  (wb_data),
        .rd_addr0 (ra0),
        .rd_data0 (rf0),
        .rd_addr1 (fs1),
        .rd_data1 (rf1)
    );

    always_comb begin
        v0 = rf0;
        if (r3_we && r3_dst == ra0)      v0 = r3_data;
        else if (wb_we && wb_dst == ra0) v0 = wb_data;
        v1 = rf1;
        if (r3_we && r3_dst == fs1)      v1 = r3_data;
        else if (wb_we && wb_dst == fs1) v1 = wb_data;
    end

    assign bubble = r2_valid && (r2_opcode == OP_LOAD) && ir_reads(ir, r2_dst)
                    && !r2_pc_flush && !r2_pc_halt;

    logic              n_halt, n_load, n_loadr, n_flush, n_valid;
    logic [A_SIZE-1:0] n_target;
    logic [3:0]        n_opcode;
    logic [2:0]        n_dst;
    logic [D_SIZE-1:0] n_op0, n_op1;

    always_comb begin
        n_halt   = r2_pc_halt;
        n_load   = 1'b0;
        n_loadr  = 1'b0;
        n_flush  = 1'b0;
        n_target = '0;
        n_valid  = 1'b0;
        n_opcode = OP_NOP;
        n_dst    = '0;
        n_op0    = '0;
        n_op1    = '0;
        if (!r2_pc_halt && !r2_pc_flush && !bubble) begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    n_valid = 1'b1; n_opcode = op; n_dst = fd; n_op0 = v0; n_op1 = v1;
                end
                OP_LOADC: begin
                    n_valid = 1'b1; n_opcode = op; n_dst = fd;
                    n_op0 = {{(D_SIZE-8){1'b0}}, ir[7:0]};
                end
                OP_LOAD: begin
                    n_valid = 1'b1; n_opcode = op; n_dst = fd; n_op0 = v0;
                end
                OP_STORE: begin
                    n_valid = 1'b1; n_opcode = op; n_op0 = v0; n_op1 = v1;
                end
                OP_JMP: begin
                    n_load = 1'b1; n_flush = 1'b1; n_target = v0[A_SIZE-1:0];
                end
                OP_JMPR: begin
                    n_loadr = 1'b1; n_flush = 1'b1; n_target = rel_tgt;
                end
                OP_JMPRZ: begin
                    if (v0 == '0) begin
                        n_loadr = 1'b1; n_flush = 1'b1; n_target = rel_tgt;
                    end
                end
                OP_HALT: n_halt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_pc_halt   <= 1'b0;
            r2_pc_load   <= 1'b0;
            r2_pc_loadr  <= 1'b0;
            r2_pc_target <= '0;
            r2_pc_flush  <= 1'b0;
            r2_valid     <= 1'b0;
            r2_opcode    <= OP_NOP;
            r2_dst       <= '0;
            r2_op0       <= '0;
            r2_op1       <= '0;
        end else begin
            r2_pc_halt   <= n_halt;
            r2_pc_load   <= n_load;
            r2_pc_loadr  <= n_loadr;
            r2_pc_target <= n_target;
            r2_pc_flush  <= n_flush;
            r2_valid     <= n_valid;
            r2_opcode    <= n_opcode;
            r2_dst       <= n_dst;
            r2_op0       <= n_op0;
            r2_op1       <= n_op1;
        end
    end

endmodule

// File: tb/tb_seq_core_read.sv
// Directed bench for seq_core_read: decode, forwarding, load-use bubble, jumps, halt, async reset.
module tb_seq_core_read;

    localparam int A_SIZE = 10;
    localparam int D_SIZE = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       ir;
    logic              r2_pc_halt, r2_pc_load, r2_pc_loadr, r2_pc_flush, bubble, r2_valid;
    logic [A_SIZE-1:0] r2_pc_target;
    logic [3:0]        r2_opcode;
    logic [2:0]        r2_dst;
    logic [D_SIZE-1:0] r2_op0, r2_op1;
    logic              r3_we, wb_we;
    logic [2:0]        r3_dst, wb_dst;
    logic [D_SIZE-1:0] r3_data, wb_data;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    seq_core_read #(.A_SIZE(A_SIZE), .D_SIZE(D_SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir),
        .r2_pc_halt(r2_pc_halt), .r2_pc_load(r2_pc_load), .r2_pc_loadr(r2_pc_loadr),
        .r2_pc_target(r2_pc_target), .r2_pc_flush(r2_pc_flush), .bubble(bubble),
        .r2_valid(r2_valid), .r2_opcode(r2_opcode), .r2_dst(r2_dst),
        .r2_op0(r2_op0), .r2_op1(r2_op1),
        .r3_we(r3_we), .r3_dst(r3_dst), .r3_data(r3_data),
        .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data)
    );

    function automatic logic [15:0] enc(input logic [3:0] o, input logic [2:0] d,
                                        input logic [2:0] s0, input logic [2:0] s1);
        return {o, d, s0, s1, 3'b000};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] r, input logic [D_SIZE-1:0] v);
        wb_we = 1'b1; wb_dst = r; wb_data = v;
        step();
        wb_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ir = 16'h0; r3_we = 0; r3_dst = 0; r3_data = 0;
        wb_we = 0; wb_dst = 0; wb_data = 0;
        #12;
        nvec++;
        if ({r2_pc_halt, r2_pc_load, r2_pc_loadr, r2_pc_flush, r2_valid, bubble} !== 6'b0 ||
            r2_pc_target !== '0 || r2_opcode !== 4'h0 || r2_dst !== 3'h0 ||
            r2_op0 !== '0 || r2_op1 !== '0) begin
            nerr++;
            $display("FAIL reset: halt=%b load=%b loadr=%b flush=%b valid=%b bubble=%b tgt=%h op=%h dst=%h op0=%h op1=%h, required all 0",
                     r2_pc_halt, r2_pc_load, r2_pc_loadr, r2_pc_flush, r2_valid, bubble,
                     r2_pc_target, r2_opcode, r2_dst, r2_op0, r2_op1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        wr(3'd1, 32'd5);
        wr(3'd2, 32'd7);
        ir = enc(4'h1, 3'd3, 3'd1, 3'd2);
        step();
        nvec++;
        if (r2_valid !== 1'b1 || r2_opcode !== 4'h1 || r2_dst !== 3'd3 ||
            r2_op0 !== 32'd5 || r2_op1 !== 32'd7) begin
            nerr++;
            $display("FAIL add: valid=%b op=%h dst=%0d op0=%0d op1=%0d, required 1 1 3 5 7",
                     r2_valid, r2_opcode, r2_dst, r2_op0, r2_op1);
        end
    endtask

    task automatic test_forward();
        // r3 beats wb on the same register; wb commits R1=4 at the edge
        ir = enc(4'h1, 3'd3, 3'd1, 3'd2);
        r3_we = 1; r3_dst = 3'd1; r3_data = 32'd9;
        wb_we = 1; wb_dst = 3'd1; wb_data = 32'd4;
        step();
        r3_we = 0; wb_we = 0;
        nvec++;
        if (r2_op0 !== 32'd9) begin
            nerr++; $display("FAIL fwd_r3: op0=%0d required 9", r2_op0);
        end
        // wb bypass on port 1, committing R2=11
        ir = enc(4'h2, 3'd6, 3'd1, 3'd2);
        wb_we = 1; wb_dst = 3'd2; wb_data = 32'd11;
        step();
        wb_we = 0;
        nvec++;
        if (r2_opcode !== 4'h2 || r2_op0 !== 32'd4 || r2_op1 !== 32'd11) begin
            nerr++; $display("FAIL fwd_wb: op=%h op0=%0d op1=%0d required 2 4 11", r2_opcode, r2_op0, r2_op1);
        end
        ir = {4'h6, 3'd5, 9'h0A5};
        step();
        nvec++;
        if (r2_valid !== 1'b1 || r2_opcode !== 4'h6 || r2_dst !== 3'd5 || r2_op0 !== 32'h0000_00A5) begin
            nerr++; $display("FAIL loadc: valid=%b op=%h dst=%0d op0=%h required 1 6 5 000000a5",
                             r2_valid, r2_opcode, r2_dst, r2_op0);
        end
    endtask

    task automatic test_load_use();
        ir = enc(4'h7, 3'd4, 3'd1, 3'd0);
        step();
        nvec++;
        if (r2_opcode !== 4'h7 || r2_dst !== 3'd4 || r2_op0 !== 32'd4 || r2_valid !== 1'b1) begin
            nerr++; $display("FAIL load: op=%h dst=%0d op0=%0d valid=%b required 7 4 4 1",
                             r2_opcode, r2_dst, r2_op0, r2_valid);
        end
        ir = enc(4'h1, 3'd5, 3'd4, 3'd2);
        #1;
        nvec++;
        if (bubble !== 1'b1) begin
            nerr++; $display("FAIL bubble_on: bubble=%b required 1", bubble);
        end
        step();
        nvec++;
        if (r2_valid !== 1'b0 || bubble !== 1'b0) begin
            nerr++; $display("FAIL bubble_nop: valid=%b bubble=%b required 0 0", r2_valid, bubble);
        end
        wb_we = 1; wb_dst = 3'd4; wb_data = 32'd33;
        step();
        wb_we = 0;
        nvec++;
        if (r2_valid !== 1'b1 || r2_opcode !== 4'h1 || r2_dst !== 3'd5 ||
            r2_op0 !== 32'd33 || r2_op1 !== 32'd11) begin
            nerr++; $display("FAIL after_bubble: valid=%b op=%h dst=%0d op0=%0d op1=%0d required 1 1 5 33 11",
                             r2_valid, r2_opcode, r2_dst, r2_op0, r2_op1);
        end
        // load followed by an instruction not reading its destination: no stall
        ir = enc(4'h7, 3'd6, 3'd1, 3'd0);
        step();
        ir = enc(4'h3, 3'd5, 3'd1, 3'd2);
        #1;
        nvec++;
        if (bubble !== 1'b0) begin
            nerr++; $display("FAIL bubble_off: bubble=%b required 0", bubble);
        end
        step();
        ir = 16'h0;
        step();
    endtask

    task automatic test_jumps();
        ir = 16'hA005;
        step();
        nvec++;
        if (r2_pc_loadr !== 1'b1 || r2_pc_flush !== 1'b1 || r2_pc_load !== 1'b0 ||
            r2_pc_target !== 10'd3 || r2_valid !== 1'b0) begin
            nerr++; $display("FAIL jmpr: loadr=%b flush=%b load=%b tgt=%0d valid=%b required 1 1 0 3 0",
                             r2_pc_loadr, r2_pc_flush, r2_pc_load, r2_pc_target, r2_valid);
        end
        ir = enc(4'h1, 3'd3, 3'd1, 3'd2);   // wrong-path slot
        step();
        nvec++;
        if (r2_pc_loadr !== 1'b0 || r2_pc_flush !== 1'b0 || r2_valid !== 1'b0) begin
            nerr++; $display("FAIL squash: loadr=%b flush=%b valid=%b required 0 0 0",
                             r2_pc_loadr, r2_pc_flush, r2_valid);
        end
        ir = 16'hA03F;                      // off6 = -1 -> target -3
        step();
        nvec++;
        if (r2_pc_target !== 10'h3FD || r2_pc_loadr !== 1'b1) begin
            nerr++; $display("FAIL jmpr_neg: tgt=%h loadr=%b required 3fd 1", r2_pc_target, r2_pc_loadr);
        end
        ir = 16'h0;
        step();
        ir = enc(4'h9, 3'd0, 3'd1, 3'd0);   // JMP R1 (=4)
        step();
        nvec++;
        if (r2_pc_load !== 1'b1 || r2_pc_loadr !== 1'b0 || r2_pc_flush !== 1'b1 || r2_pc_target !== 10'd4) begin
            nerr++; $display("FAIL jmp: load=%b loadr=%b flush=%b tgt=%0d required 1 0 1 4",
                             r2_pc_load, r2_pc_loadr, r2_pc_flush, r2_pc_target);
        end
        ir = 16'h0;
        step();
        nvec++;
        if (r2_pc_load !== 1'b0 || r2_pc_flush !== 1'b0) begin
            nerr++; $display("FAIL jmp_once: load=%b flush=%b required 0 0", r2_pc_load, r2_pc_flush);
        end
    endtask

    task automatic test_jmprz();
        wr(3'd6, 32'd0);
        wr(3'd7, 32'd1);
        ir = 16'hBC02;                      // JMPRZ R6, +2
        step();
        nvec++;
        if (r2_pc_loadr !== 1'b1 || r2_pc_flush !== 1'b1 || r2_pc_target !== 10'd0) begin
            nerr++; $display("FAIL jmprz_taken: loadr=%b flush=%b tgt=%0d required 1 1 0",
                             r2_pc_loadr, r2_pc_flush, r2_pc_target);
        end
        // reset asserted mid-jump clears outputs without a clock edge
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if (r2_pc_loadr !== 1'b0 || r2_pc_flush !== 1'b0 || r2_pc_target !== '0) begin
            nerr++; $display("FAIL async_rst_jump: loadr=%b flush=%b tgt=%0d required 0 0 0",
                             r2_pc_loadr, r2_pc_flush, r2_pc_target);
        end
        ir = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        ir = 16'hBE02;                      // JMPRZ R7, +2 (R7=1: untaken)
        step();
        nvec++;
        if (r2_pc_loadr !== 1'b0 || r2_pc_load !== 1'b0 || r2_pc_flush !== 1'b0 || r2_valid !== 1'b0) begin
            nerr++; $display("FAIL jmprz_untaken: loadr=%b load=%b flush=%b valid=%b required 0 0 0 0",
                             r2_pc_loadr, r2_pc_load, r2_pc_flush, r2_valid);
        end
    endtask

    task automatic test_halt();
        int bad;
        ir = 16'hF000;
        step();
        nvec++;
        if (r2_pc_halt !== 1'b1) begin
            nerr++; $display("FAIL halt_set: halt=%b required 1", r2_pc_halt);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            ir = (i % 2 == 0) ? 16'hA005 : enc(4'h1, 3'd3, 3'd1, 3'd2);
            step();
            if (r2_pc_halt !== 1'b1 || r2_valid !== 1'b0 || r2_pc_loadr !== 1'b0 ||
                r2_pc_flush !== 1'b0 || bubble !== 1'b0) bad++;
        end
        nvec++;
        if (bad != 0) begin
            nerr++; $display("FAIL halt_hold: %0d bad cycles, required 0", bad);
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if (r2_pc_halt !== 1'b0 || r2_valid !== 1'b0) begin
            nerr++; $display("FAIL async_rst_halt: halt=%b valid=%b required 0 0", r2_pc_halt, r2_valid);
        end
        ir = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_load_use();
        test_jumps();
        test_jmprz();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
